// File: rtl/alu_dispatcher_if.sv
// Decode-side request, ALU control/response and writeback signals of alu_dispatcher.
// The slave modport is the dispatcher; the master modport is its surroundings.
interface alu_dispatcher_if #(
    parameter int unsigned OPERAND_WIDTH    = 64,
    parameter int unsigned OPCODE_ALU_WIDTH = 4,
    parameter int unsigned RD_WIDTH         = 5
);
    logic                        in_valid;
    logic                        in_ready;
    logic [OPCODE_ALU_WIDTH-1:0] in_op;
    logic [OPERAND_WIDTH-1:0]    in_a;
    logic [OPERAND_WIDTH-1:0]    in_b;
    logic [RD_WIDTH-1:0]         in_rd;

    logic [OPERAND_WIDTH-1:0]    alu_operand_1;
    logic [OPERAND_WIDTH-1:0]    alu_operand_2;
    logic [OPCODE_ALU_WIDTH-1:0] alu_op_code;
    logic                        alu_enable_comb;
    logic                        alu_enable_seq;
    logic                        alu_idle;
    logic [OPERAND_WIDTH-1:0]    alu_result_1cycle;
    logic [OPERAND_WIDTH-1:0]    alu_result_multi_cycle;

    logic                        wb_valid;
    logic                        wb_ready;
    logic [OPERAND_WIDTH-1:0]    wb_data;
    logic [RD_WIDTH-1:0]         wb_rd;
    logic                        wb_error;

    modport master (
        output in_valid, in_op, in_a, in_b, in_rd,
        input  in_ready,
        input  alu_operand_1, alu_operand_2, alu_op_code, alu_enable_comb, alu_enable_seq,
        output alu_idle, alu_result_1cycle, alu_result_multi_cycle,
        input  wb_valid, wb_data, wb_rd, wb_error,
        output wb_ready
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd,
        output in_ready,
        output alu_operand_1, alu_operand_2, alu_op_code, alu_enable_comb, alu_enable_seq,
        input  alu_idle, alu_result_1cycle, alu_result_multi_cycle,
        output wb_valid, wb_data, wb_rd, wb_error,
        input  wb_ready
    );
endinterface

// File: rtl/alu_dispatcher.sv
// Issues one decoded ALU op at a time to a single-cycle or multi-cycle ALU path
// and holds the result (or an error) on a valid/ready writeback port.
module alu_dispatcher #(
    parameter int unsigned OPERAND_WIDTH    = 64,
    parameter int unsigned OPCODE_ALU_WIDTH = 4,
    parameter int unsigned RD_WIDTH         = 5,
    parameter int unsigned TIMEOUT_CYCLES   = 256,
    parameter int unsigned ADD_ALU_ENCODE   = 0,
    parameter int unsigned SUB_ALU_ENCODE   = 1,
    parameter int unsigned SLT_ALU_ENCODE   = 2,
    parameter int unsigned AND_ALU_ENCODE   = 3,
    parameter int unsigned XOR_ALU_ENCODE   = 4,
    parameter int unsigned OR_ALU_ENCODE    = 5,
    parameter int unsigned SRL_ALU_ENCODE   = 6,
    parameter int unsigned SLL_ALU_ENCODE   = 7,
    parameter int unsigned MUL_ALU_ENCODE   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_dispatcher_if.slave bus
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMB,
        S_SEQ_WAIT,
        S_WB
    } state_t;

    typedef logic [OPCODE_ALU_WIDTH-1:0] opcode_t;
    typedef logic [OPERAND_WIDTH-1:0]    operand_t;
    typedef logic [RD_WIDTH-1:0]         rd_t;

    function automatic logic is_seq_op(input opcode_t op);
        return (op == OPCODE_ALU_WIDTH'(SLL_ALU_ENCODE)) ||
               (op == OPCODE_ALU_WIDTH'(SRL_ALU_ENCODE)) ||
               (op == OPCODE_ALU_WIDTH'(MUL_ALU_ENCODE));
    endfunction

    function automatic logic is_comb_op(input opcode_t op);
        return (op == OPCODE_ALU_WIDTH'(ADD_ALU_ENCODE)) ||
               (op == OPCODE_ALU_WIDTH'(SUB_ALU_ENCODE)) ||
               (op == OPCODE_ALU_WIDTH'(SLT_ALU_ENCODE)) ||
               (op == OPCODE_ALU_WIDTH'(AND_ALU_ENCODE)) ||
               (op == OPCODE_ALU_WIDTH'(XOR_ALU_ENCODE)) ||
               (op == OPCODE_ALU_WIDTH'(OR_ALU_ENCODE));
    endfunction

    state_t     state_q,    state_d;
    logic       in_ready_q, in_ready_d;
    operand_t   op1_q,      op1_d;
    operand_t   op2_q,      op2_d;
    opcode_t    opc_q,      opc_d;
    logic       en_comb_q,  en_comb_d;
    logic       en_seq_q,   en_seq_d;
    logic       wb_valid_q, wb_valid_d;
    operand_t   wb_data_q,  wb_data_d;
    rd_t        wb_rd_q,    wb_rd_d;
    logic       wb_error_q, wb_error_d;
    rd_t        rd_q,       rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       seen_busy_q, seen_busy_d;
    logic       seq_done;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            op1_q       <= '0;
            op2_q       <= '0;
            opc_q       <= '0;
            en_comb_q   <= 1'b0;
            en_seq_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_error_q  <= 1'b0;
            rd_q        <= '0;
            cnt_q       <= '0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            opc_q       <= opc_d;
            en_comb_q   <= en_comb_d;
            en_seq_q    <= en_seq_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_error_q  <= wb_error_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            seen_busy_q <= seen_busy_d;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        opc_d       = opc_q;
        en_comb_d   = en_comb_q;
        en_seq_d    = en_seq_q;
        wb_valid_d  = wb_valid_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_error_d  = wb_error_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        seen_busy_d = seen_busy_q;
        seq_done    = seen_busy_q && bus.alu_idle;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    rd_d = bus.in_rd;
                    if (is_seq_op(bus.in_op)) begin
                        state_d     = S_SEQ_WAIT;
                        op1_d       = bus.in_a;
                        op2_d       = bus.in_b;
                        opc_d       = bus.in_op;
                        en_seq_d    = 1'b1;
                        cnt_d       = '0;
                        seen_busy_d = 1'b0;
                    end else if (is_comb_op(bus.in_op)) begin
                        state_d   = S_COMB;
                        op1_d     = bus.in_a;
                        op2_d     = bus.in_b;
                        opc_d     = bus.in_op;
                        en_comb_d = 1'b1;
                    end else begin
                        state_d    = S_WB;
                        wb_valid_d = 1'b1;
                        wb_data_d  = '0;
                        wb_error_d = 1'b1;
                        wb_rd_d    = bus.in_rd;
                    end
                end
            end

            S_COMB: begin
                state_d    = S_WB;
                en_comb_d  = 1'b0;
                op1_d      = '0;
                op2_d      = '0;
                opc_d      = '0;
                wb_valid_d = 1'b1;
                wb_data_d  = bus.alu_result_1cycle;
                wb_error_d = 1'b0;
                wb_rd_d    = rd_q;
            end

            // Completion needs a busy phase first so a stale idle cannot end the op early.
            S_SEQ_WAIT: begin
                if (!bus.alu_idle) begin
                    seen_busy_d = 1'b1;
                end
                if (seq_done || (cnt_q == CNT_LAST)) begin
                    state_d    = S_WB;
                    en_seq_d   = 1'b0;
                    op1_d      = '0;
                    op2_d      = '0;
                    opc_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = seq_done ? bus.alu_result_multi_cycle : '0;
                    wb_error_d = !seq_done;
                    wb_rd_d    = rd_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WB: begin
                if (bus.wb_ready) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.alu_operand_1   = op1_q;
    assign bus.alu_operand_2   = op2_q;
    assign bus.alu_op_code     = opc_q;
    assign bus.alu_enable_comb = en_comb_q;
    assign bus.alu_enable_seq  = en_seq_q;
    assign bus.wb_valid        = wb_valid_q;
    assign bus.wb_data         = wb_data_q;
    assign bus.wb_rd           = wb_rd_q;
    assign bus.wb_error        = wb_error_q;

endmodule

// File: tb/tb_alu_dispatcher.sv
// Bench for alu_dispatcher: directed scenarios plus randomized ops against an
// arithmetic reference model, with a behavioural ALU attached to the dispatcher.
module tb_alu_dispatcher;
    localparam int unsigned W       = 64;
    localparam int unsigned OPW     = 4;
    localparam int unsigned RDW     = 5;
    localparam int unsigned TIMEOUT = 256;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLT = 4'd2, OP_AND = 4'd3,
                           OP_XOR = 4'd4, OP_OR  = 4'd5, OP_SRL = 4'd6, OP_SLL = 4'd7,
                           OP_MUL = 4'd8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    alu_dispatcher_if #(.OPERAND_WIDTH(W), .OPCODE_ALU_WIDTH(OPW), .RD_WIDTH(RDW)) bus ();

    alu_dispatcher #(
        .OPERAND_WIDTH(W), .OPCODE_ALU_WIDTH(OPW), .RD_WIDTH(RDW), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference: what each opcode means arithmetically.
    function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_SRL:  return a >> b[5:0];
            OP_SLL:  return a << b[5:0];
            OP_MUL:  return a * b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit is_multi(input logic [3:0] op);
        return (op == OP_SRL) || (op == OP_SLL) || (op == OP_MUL);
    endfunction

    // Behavioural ALU: combinational single-cycle path, multi-cycle unit started by a rising enable.
    int unsigned  cyc           = 0;
    int unsigned  mul_lat       = 3;
    bit           alu_stuck     = 1'b0;
    int unsigned  seq_rises     = 0;
    int unsigned  comb_cycles   = 0;
    int unsigned  idle_rise_cyc = 0;
    int unsigned  busy_left     = 0;
    logic         prev_seq      = 1'b0;
    logic         alu_idle_m    = 1'b1;
    logic [W-1:0] multi_res_m   = 64'hDEAD_BEEF_DEAD_BEEF;
    logic [W-1:0] pending       = '0;

    assign bus.alu_idle               = alu_idle_m;
    assign bus.alu_result_multi_cycle = multi_res_m;

    always_comb begin
        bus.alu_result_1cycle = bus.alu_enable_comb
            ? ref_result(bus.alu_op_code, bus.alu_operand_1, bus.alu_operand_2)
            : 64'hBADC_0FFE_E0DD_F00D;
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_seq <= bus.alu_enable_seq;
        if (bus.alu_enable_comb) comb_cycles <= comb_cycles + 1;
        if (bus.alu_enable_seq && !prev_seq) begin
            seq_rises <= seq_rises + 1;
            if (!alu_stuck) begin
                alu_idle_m  <= 1'b0;
                busy_left   <= mul_lat;
                pending     <= ref_result(bus.alu_op_code, bus.alu_operand_1, bus.alu_operand_2);
                multi_res_m <= 64'hDEAD_BEEF_DEAD_BEEF;
            end
        end else if (busy_left != 0) begin
            if (busy_left == 1) begin
                alu_idle_m    <= 1'b1;
                multi_res_m   <= pending;
                idle_rise_cyc <= cyc + 1;
            end
            busy_left <= busy_left - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [RDW-1:0] rd);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_rd    = rd;
        tick();
        bus.in_valid = 1'b0;
        bus.in_op    = 4'(OP_ADD);
        bus.in_a     = {$urandom, $urandom};
        bus.in_b     = {$urandom, $urandom};
        bus.in_rd    = RDW'($urandom);
    endtask

    task automatic wait_wb(input int unsigned limit, output int unsigned n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n <= limit) begin
            if (bus.wb_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_rd    = '0;
        bus.wb_ready = 1'b0;
        repeat (3) tick();
        checks++; if (bus.wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0b want=0", bus.wb_valid); end
        checks++; if ({bus.wb_data, bus.wb_rd, bus.wb_error} !== '0) begin failures++; $display("FAIL reset_wb_payload got=%0h/%0d/%0b want=0", bus.wb_data, bus.wb_rd, bus.wb_error); end
        checks++; if ({bus.alu_enable_comb, bus.alu_enable_seq} !== 2'b00) begin failures++; $display("FAIL reset_enables got=%b want=00", {bus.alu_enable_comb, bus.alu_enable_seq}); end
        checks++; if ({bus.alu_operand_1, bus.alu_operand_2, bus.alu_op_code} !== '0) begin failures++; $display("FAIL reset_alu_bus got=%0h/%0h/%0h want=0", bus.alu_operand_1, bus.alu_operand_2, bus.alu_op_code); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
    endtask

    task automatic test_add();
        int unsigned c0;
        bus.wb_ready = 1'b1;
        c0 = comb_cycles;
        issue(OP_ADD, 64'd5, 64'd7, 5'd3);
        checks++; if (bus.alu_enable_comb !== 1'b1) begin failures++; $display("FAIL add_enable_comb got=%0b want=1", bus.alu_enable_comb); end
        checks++; if ({bus.alu_operand_1, bus.alu_operand_2, bus.alu_op_code} !== {64'd5, 64'd7, OP_ADD}) begin failures++; $display("FAIL add_alu_bus got=%0h/%0h/%0h want=5/7/0", bus.alu_operand_1, bus.alu_operand_2, bus.alu_op_code); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL add_in_ready_busy got=%0b want=0", bus.in_ready); end
        tick();
        checks++; if (bus.wb_valid !== 1'b1) begin failures++; $display("FAIL add_wb_valid_t2 got=%0b want=1", bus.wb_valid); end
        checks++; if ({bus.wb_data, bus.wb_rd, bus.wb_error} !== {64'd12, 5'd3, 1'b0}) begin failures++; $display("FAIL add_wb_payload got=%0d/%0d/%0b want=12/3/0", bus.wb_data, bus.wb_rd, bus.wb_error); end
        checks++; if (bus.alu_enable_comb !== 1'b0 || comb_cycles - c0 != 1) begin failures++; $display("FAIL add_enable_pulse got_en=%0b cycles=%0d want=0/1", bus.alu_enable_comb, comb_cycles - c0); end
        checks++; if ({bus.alu_operand_1, bus.alu_operand_2, bus.alu_op_code} !== '0) begin failures++; $display("FAIL add_alu_bus_wb got=%0h/%0h/%0h want=0", bus.alu_operand_1, bus.alu_operand_2, bus.alu_op_code); end
        tick();
        checks++; if ({bus.wb_valid, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL add_return_idle got=%b want=01", {bus.wb_valid, bus.in_ready}); end
    endtask

    task automatic test_mul();
        logic [W-1:0] ta [3] = '{64'd6, 64'd0, 64'h1234_5678_9ABC_DEF0};
        logic [W-1:0] tb [3] = '{64'd7, 64'hFFFF_0000_FFFF_0000, 64'd0};
        int unsigned  tl [3] = '{4, 2, 5};
        logic [W-1:0] want;
        int unsigned  r0, n;
        bit           ok;
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mul_lat = tl[i];
            r0      = seq_rises;
            want    = (i == 0) ? 64'd42 : 64'd0;
            issue(OP_MUL, ta[i], tb[i], 5'(i + 10));
            checks++; if (bus.alu_enable_seq !== 1'b1) begin failures++; $display("FAIL mul%0d_enable_seq_first got=%0b want=1", i, bus.alu_enable_seq); end
            wait_wb(64, n, ok);
            checks++; if (!ok) begin failures++; $display("FAIL mul%0d_wb_timeout got=none want=wb_valid", i); end
            checks++; if ({bus.wb_data, bus.wb_rd, bus.wb_error} !== {want, 5'(i + 10), 1'b0}) begin failures++; $display("FAIL mul%0d_wb_payload got=%0h/%0d/%0b want=%0h/%0d/0", i, bus.wb_data, bus.wb_rd, bus.wb_error, want, i + 10); end
            checks++; if (cyc - idle_rise_cyc != 1) begin failures++; $display("FAIL mul%0d_wb_after_idle got=%0d want=1", i, cyc - idle_rise_cyc); end
            checks++; if (seq_rises - r0 != 1 || bus.alu_enable_seq !== 1'b0) begin failures++; $display("FAIL mul%0d_enable_seq_edges got=%0d/%0b want=1/0", i, seq_rises - r0, bus.alu_enable_seq); end
            tick();
        end
        mul_lat = 3;
    endtask

    task automatic test_shifts();
        logic [3:0]   op [2] = '{OP_SLL, OP_SRL};
        logic [W-1:0] a  [2] = '{64'd1, 64'h80};
        logic [W-1:0] b  [2] = '{64'd4, 64'd3};
        logic [W-1:0] r  [2] = '{64'd16, 64'h10};
        int unsigned  n;
        bit           ok;
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(op[i], a[i], b[i], 5'd21);
            wait_wb(64, n, ok);
            checks++; if (!ok || bus.wb_data !== r[i] || bus.wb_error !== 1'b0) begin failures++; $display("FAIL shift%0d_result got=%0h/%0b ok=%0b want=%0h/0", i, bus.wb_data, bus.wb_error, ok, r[i]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bus.wb_ready = 1'b0;
        issue(OP_ADD, 64'd1, 64'd1, 5'd7);
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if ({bus.wb_valid, bus.in_ready, bus.wb_data, bus.wb_rd} !== {1'b1, 1'b0, 64'd2, 5'd7}) begin failures++; $display("FAIL stall_hold_%0d got=%0b/%0b/%0d/%0d want=1/0/2/7", i, bus.wb_valid, bus.in_ready, bus.wb_data, bus.wb_rd); end
            if (i < 2) tick();
        end
        bus.wb_ready = 1'b1;
        tick();
        checks++; if ({bus.wb_valid, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL stall_release got=%b want=01", {bus.wb_valid, bus.in_ready}); end
    endtask

    task automatic test_illegal();
        int unsigned c0, r0;
        bus.wb_ready = 1'b0;
        c0 = comb_cycles;
        r0 = seq_rises;
        issue(4'd15, 64'd99, 64'd1, 5'd4);
        tick();
        checks++; if ({bus.wb_valid, bus.wb_error, bus.wb_data, bus.wb_rd} !== {1'b1, 1'b1, 64'd0, 5'd4}) begin failures++; $display("FAIL illegal_wb got=%0b/%0b/%0h/%0d want=1/1/0/4", bus.wb_valid, bus.wb_error, bus.wb_data, bus.wb_rd); end
        checks++; if (comb_cycles != c0 || seq_rises != r0 || bus.alu_enable_comb !== 1'b0 || bus.alu_enable_seq !== 1'b0) begin failures++; $display("FAIL illegal_no_enable got=%0d/%0d want=0/0", comb_cycles - c0, seq_rises - r0); end
        bus.wb_ready = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        int unsigned n;
        bit          ok;
        alu_stuck    = 1'b1;
        bus.wb_ready = 1'b1;
        issue(OP_MUL, 64'd3, 64'd9, 5'd30);
        wait_wb(TIMEOUT + 16, n, ok);
        checks++; if (!ok || n != TIMEOUT) begin failures++; $display("FAIL timeout_latency got=%0d ok=%0b want=%0d", n, ok, TIMEOUT); end
        checks++; if ({bus.wb_error, bus.wb_data, bus.wb_rd} !== {1'b1, 64'd0, 5'd30}) begin failures++; $display("FAIL timeout_payload got=%0b/%0h/%0d want=1/0/30", bus.wb_error, bus.wb_data, bus.wb_rd); end
        tick();
        alu_stuck = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int seen_wb = 0;
        mul_lat      = 20;
        bus.wb_ready = 1'b1;
        issue(OP_MUL, 64'd3, 64'd5, 5'd2);
        repeat (3) tick();
        checks++; if (bus.alu_enable_seq !== 1'b1) begin failures++; $display("FAIL abort_pre_enable got=%0b want=1", bus.alu_enable_seq); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.alu_enable_seq, bus.alu_enable_comb, bus.wb_valid, bus.wb_error} !== 4'b0000 || {bus.alu_operand_1, bus.alu_operand_2, bus.alu_op_code, bus.wb_data, bus.wb_rd} !== '0) begin failures++; $display("FAIL abort_outputs got=%b/%0h want=0000/0", {bus.alu_enable_seq, bus.alu_enable_comb, bus.wb_valid, bus.wb_error}, bus.alu_operand_1); end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.wb_valid !== 1'b0) seen_wb++;
        end
        checks++; if (seen_wb != 0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL abort_no_wb got=%0d/%0b want=0/1", seen_wb, bus.in_ready); end
        mul_lat = 3;
    endtask

    task automatic test_back_to_back();
        int unsigned acc[$];
        int          bad_data = 0;
        bus.wb_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op    = OP_ADD;
        bus.in_a     = 64'd2;
        bus.in_b     = 64'd3;
        bus.in_rd    = 5'd1;
        for (int i = 0; i < 10; i++) begin
            if (bus.in_ready === 1'b1) acc.push_back(cyc + 1);
            if (bus.wb_valid === 1'b1 && bus.wb_data !== 64'd5) bad_data++;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (acc.size() != 4) begin failures++; $display("FAIL b2b_accepts got=%0d want=4", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++; if (acc[i] - acc[i-1] != 3) begin failures++; $display("FAIL b2b_spacing_%0d got=%0d want=3", i, acc[i] - acc[i-1]); end
        end
        checks++; if (bad_data != 0) begin failures++; $display("FAIL b2b_data got=%0d bad want=0", bad_data); end
        for (int i = 0; i < 8 && bus.in_ready !== 1'b1; i++) tick();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_drain got=%0b want=1", bus.in_ready); end
    endtask

    task automatic test_random();
        logic [3:0]     op;
        logic [W-1:0]   a, b, want;
        logic [RDW-1:0] rd;
        logic [W+RDW+1:0] snap;
        int unsigned    n, hold;
        bit             ok;
        int             unstable;
        for (int k = 0; k < 60; k++) begin
            op      = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            a       = {$urandom, $urandom};
            b       = ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom, $urandom};
            rd      = RDW'($urandom);
            mul_lat = $urandom_range(1, 6);
            hold    = $urandom_range(0, 3);
            want    = (op <= OP_MUL) ? ref_result(op, a, b) : 64'd0;
            bus.wb_ready = 1'b0;
            issue(op, a, b, rd);
            wait_wb(64, n, ok);
            checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_no_wb op=%0d", k, op); end
            if (op > OP_MUL) begin
                checks++; if (n != 0) begin failures++; $display("FAIL rnd%0d_illegal_latency got=%0d want=0", k, n); end
            end else if (is_multi(op)) begin
                checks++; if (cyc - idle_rise_cyc != 1) begin failures++; $display("FAIL rnd%0d_multi_latency got=%0d want=1", k, cyc - idle_rise_cyc); end
            end else begin
                checks++; if (n != 1) begin failures++; $display("FAIL rnd%0d_comb_latency got=%0d want=1", k, n); end
            end
            snap     = {bus.wb_valid, bus.wb_error, bus.wb_data, bus.wb_rd};
            unstable = 0;
            for (int h = 0; h < int'(hold); h++) begin
                tick();
                if ({bus.wb_valid, bus.wb_error, bus.wb_data, bus.wb_rd} !== snap) unstable++;
            end
            checks++; if (unstable != 0) begin failures++; $display("FAIL rnd%0d_hold got=%0d changes want=0", k, unstable); end
            checks++; if ({bus.wb_data, bus.wb_rd, bus.wb_error} !== {want, rd, (op > OP_MUL)}) begin failures++; $display("FAIL rnd%0d_payload op=%0d got=%0h/%0d/%0b want=%0h/%0d/%0b", k, op, bus.wb_data, bus.wb_rd, bus.wb_error, want, rd, op > OP_MUL); end
            bus.wb_ready = 1'b1;
            tick();
        end
        mul_lat = 3;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_shifts();
        test_backpressure();
        test_illegal();
        test_timeout();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
